// File: rtl/fifo_pkg.sv
// Shared width helpers and status-flag type for the synchronous FIFO.
package fifo_pkg;

  // Pointer width for a power-of-two depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/param_sync_fifo_if.sv
// Write/read handshake, status and error bundle for param_sync_fifo.
interface param_sync_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  import fifo_pkg::*;

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with status/sticky-error flags and flush.
// Optional first-word-fall-through read path: define PARAM_SYNC_FIFO_FWFT_EN.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  param_sync_fifo_if.slave bus
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  // Reject unsupported configurations at elaboration.
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("param_sync_fifo: DATA_W must be 1..32");
  end
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two in 4..256");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LVL must be 1..DEPTH");
  end
  if (AE_LVL >= AF_LVL) begin : g_bad_ae
    $error("param_sync_fifo: AE_LVL must be below AF_LVL");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_status_t      status_q, status_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Acceptance, pointer/count/flag next state and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    rd_acc = bus.rd_en && !status_q.empty && !bus.flush;
    wr_acc = bus.wr_en && (!status_q.full || rd_acc) && !bus.flush;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    status_d.full         = (count_d == CNT_W'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CNT_W'(AF_LVL));
    status_d.almost_empty = (count_d <= CNT_W'(AE_LVL));

    // Clear first so a same-cycle error wins over err_clr.
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.wr_en && !bus.flush && !wr_acc)         ovf_d = 1'b1;
    if (bus.rd_en && !bus.flush && status_q.empty)  udf_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word is presented directly; zeroed while empty so reset/flush read as 0.
  assign bus.rd_data  = status_q.empty ? '0 : mem_rdata;
  assign bus.rd_valid = !status_q.empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Registered read path: capture head on an accepted pop, hold otherwise.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_acc) begin
      rd_data_d  = mem_rdata;
      rd_valid_d = 1'b1;
    end
  end

  // Read data/valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = status_q.full;
  assign bus.empty        = status_q.empty;
  assign bus.almost_full  = status_q.almost_full;
  assign bus.almost_empty = status_q.almost_empty;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DATA_W=8, DEPTH=16).
// Follows PARAM_SYNC_FIFO_FWFT_EN to select the expected read timing.
module tb_param_sync_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [DW-1:0] exp_words [16];
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] data_ctr;

  param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  param_sync_fifo #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_count"}, 32'(bus.count), 32'd0);
    check({pfx, "_empty"}, 32'(bus.empty), 32'd1);
    check({pfx, "_ae"},    32'(bus.almost_empty), 32'd1);
    check({pfx, "_full"},  32'(bus.full), 32'd0);
    check({pfx, "_af"},    32'(bus.almost_full), 32'd0);
    check({pfx, "_rv"},    32'(bus.rd_valid), 32'd0);
    check({pfx, "_rd"},    32'(bus.rd_data), 32'd0);
    check({pfx, "_ovf"},   32'(bus.overflow), 32'd0);
    check({pfx, "_udf"},   32'(bus.underflow), 32'd0);
  endtask

  // One cycle of traffic against a reference queue.
  task automatic step(input bit wr, input bit rd);
    bit            rd_ok;
    bit            wr_ok;
    logic [DW-1:0] exp_d;
    rd_ok = rd && (model_q.size() != 0);
    wr_ok = wr && (model_q.size() < int'(DP) || rd_ok);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    check("st_ff_rv", 32'(bus.rd_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("st_ff_rd", 32'(bus.rd_data), 32'(model_q[0]));
`endif
    exp_d = '0;
    if (rd_ok) exp_d = model_q.pop_front();
    if (wr_ok) model_q.push_back(data_ctr);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.wr_data = data_ctr;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    if (wr_ok) data_ctr = data_ctr + 8'd1;
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("st_rv", 32'(bus.rd_valid), 32'(rd_ok));
    if (rd_ok) check("st_rd", 32'(bus.rd_data), 32'(exp_d));
`endif
    check("st_count", 32'(bus.count), 32'(model_q.size()));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    data_ctr = 8'h40;
    for (int i = 0; i < 16; i++) exp_words[i] = (i == 15) ? 8'h10 : 8'(8'h11 + i);

    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset("rst");
    #9 rst_n = 1'b1;
    tick();

    // Fill to full with 0x11..0x1F,0x10.
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = exp_words[i];
      tick();
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_af",    32'(bus.almost_full), 32'((i + 1) >= 14));
      check("fill_ae",    32'(bus.almost_empty), 32'((i + 1) <= 2));
      check("fill_full",  32'(bus.full), 32'(i == 15));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      if (i == 0) begin
        check("fwft_first_rv", 32'(bus.rd_valid), 32'd1);
        check("fwft_first_rd", 32'(bus.rd_data), 32'h11);
      end
`endif
    end
    bus.wr_en = 1'b0;

    // Write while full.
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_full",  32'(bus.full), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Drain in order.
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    for (int i = 0; i < 16; i++) begin
      check("drain_rv", 32'(bus.rd_valid), 32'd1);
      check("drain_rd", 32'(bus.rd_data), 32'(exp_words[i]));
      bus.rd_en = 1'b1;
      tick();
      check("drain_count", 32'(bus.count), 32'(15 - i));
    end
    bus.rd_en = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_rv_end", 32'(bus.rd_valid), 32'd0);
`else
    for (int i = 0; i < 16; i++) begin
      bus.rd_en = 1'b1;
      tick();
      check("drain_rv",    32'(bus.rd_valid), 32'd1);
      check("drain_rd",    32'(bus.rd_data), 32'(exp_words[i]));
      check("drain_count", 32'(bus.count), 32'(15 - i));
    end
    bus.rd_en = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    tick();
    check("drain_rv_end", 32'(bus.rd_valid), 32'd0);
    check("drain_hold",   32'(bus.rd_data), 32'h10);
`endif

    // Read while empty, with err_clr in the same cycle: set wins.
    bus.rd_en   = 1'b1;
    bus.err_clr = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    check("udf_set",   32'(bus.underflow), 32'd1);
    check("udf_count", 32'(bus.count), 32'd0);
    check("udf_rv",    32'(bus.rd_valid), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("udf_clr", 32'(bus.underflow), 32'd0);

    // Wrap-around traffic with simultaneous read/write at full and at empty.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("wrap_full", 32'(bus.full), 32'd1);
    check("wrap_no_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    check("wrap_empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("wrap_udf", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("wrap_drained", 32'(bus.empty), 32'd1);

    // Flush with same-cycle write/read requests.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 8'h99;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    model_q.delete();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_rv",    32'(bus.rd_valid), 32'd0);
    check("flush_udf",   32'(bus.underflow), 32'd1);
    check("flush_ovf",   32'(bus.overflow), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Reset asserted in the middle of a write burst.
    step(1'b0, 1'b1);
    check("pre_rst_udf", 32'(bus.underflow), 32'd1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC1;
    tick();
    bus.wr_data = 8'hC2;
    tick();
    check("pre_rst_count", 32'(bus.count), 32'd2);
    #3 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    bus.wr_en = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    model_q.delete();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
